seq_alu_flags: RTL and testbench



---
 rtl/seq_alu_flags.sv | 228 ++++++++++++++++++++++
 tb/tb_seq_alu_flags.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_flags.sv
// rtl/seq_alu_flags.sv - sequential N-bit ALU with registered N/Z/C/V flags and busy/done handshake
// Optional feature macro: MULT_ITER_EN (iterative shift-add multiplier instead of single-cycle MUL).
module seq_alu_flags #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [3:0]   i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_flag_n,
  output logic         o_flag_z,
  output logic         o_flag_c,
  output logic         o_flag_v
);
  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_finish;
  logic            w_iter_op;
  logic [3:0]      r_op;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_quo;
  logic [CW-1:0]   r_cnt;

  logic [N:0]      w_sum;
  logic [N:0]      w_dif;
  logic [N:0]      w_shl;
  logic [N:0]      w_shr;
  logic [N:0]      w_rem_sh;
  logic            w_ge;
  logic [N-1:0]    w_rem_nxt;
  logic [N-1:0]    w_quo_nxt;
  logic [N-1:0]    w_res;
  logic            w_c;
  logic            w_v;
  logic            w_z_en;

`ifdef MULT_ITER_EN
  logic [2*N-1:0]  r_acc;
  logic [2*N-1:0]  r_mcand;
  logic [N-1:0]    r_mplier;
  logic [2*N-1:0]  w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_iter_op = ((r_op == OP_DIV || r_op == OP_MOD) && r_b != '0) || (r_op == OP_MUL);
`else
  logic [2*N-1:0]  w_prod;

  assign w_prod    = {{N{1'b0}}, r_a} * {{N{1'b0}}, r_b};
  assign w_iter_op = (r_op == OP_DIV || r_op == OP_MOD) && r_b != '0;
`endif

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};
  // Extra bit catches the last bit shifted out, which is the C flag.
  assign w_shl = {1'b0, r_a} << r_b;
  assign w_shr = {r_a, 1'b0} >> r_b;

  // Restoring divide step: quotient register feeds dividend bits MSB first.
  assign w_rem_sh  = {r_rem, r_quo[N-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_b};
  assign w_rem_nxt = w_ge ? N'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[N-1:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_iter_op) begin
          w_state_nxt = S_ITER;
        end else begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      S_ITER: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_z_en = 1'b1;
    if (r_state == S_ITER) begin
`ifdef MULT_ITER_EN
      if (r_op == OP_MUL) begin
        w_res = w_acc_nxt[N-1:0];
        w_c   = |w_acc_nxt[2*N-1:N];
      end else begin
        w_res = (r_op == OP_DIV) ? w_quo_nxt : w_rem_nxt;
      end
`else
      w_res = (r_op == OP_DIV) ? w_quo_nxt : w_rem_nxt;
`endif
    end else begin
      case (r_op)
        OP_ADD: begin
          w_res = w_sum[N-1:0];
          w_c   = w_sum[N];
          w_v   = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
        end
        OP_SUB: begin
          w_res = w_dif[N-1:0];
          w_c   = w_dif[N];
          w_v   = (r_a[N-1] != r_b[N-1]) && (w_dif[N-1] != r_a[N-1]);
        end
        OP_MUL: begin
`ifdef MULT_ITER_EN
          w_res = '0;
`else
          w_res = w_prod[N-1:0];
          w_c   = |w_prod[2*N-1:N];
`endif
        end
        // Only reached here with a zero divisor: divide-by-zero reporting.
        OP_DIV, OP_MOD: begin
          w_v    = 1'b1;
          w_z_en = 1'b0;
        end
        OP_AND: w_res = r_a & r_b;
        OP_OR:  w_res = r_a | r_b;
        OP_XOR: w_res = r_a ^ r_b;
        OP_SHL: begin
          w_res = w_shl[N-1:0];
          w_c   = w_shl[N];
        end
        OP_SHR: begin
          w_res = w_shr[N:1];
          w_c   = w_shr[0];
        end
        default: w_z_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_flag_n <= 1'b0;
      o_flag_z <= 1'b0;
      o_flag_c <= 1'b0;
      o_flag_v <= 1'b0;
`ifdef MULT_ITER_EN
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`endif
    end else begin
      o_busy <= (w_state_nxt != S_IDLE);
      o_done <= w_finish;
      if (r_state == S_IDLE && i_start) begin
        r_op <= i_op;
        r_a  <= i_a;
        r_b  <= i_b;
      end
      if (r_state == S_EXEC) begin
        r_rem <= '0;
        r_quo <= r_a;
        r_cnt <= CW'(N - 1);
`ifdef MULT_ITER_EN
        r_acc    <= '0;
        r_mcand  <= {{N{1'b0}}, r_a};
        r_mplier <= r_b;
`endif
      end else if (r_state == S_ITER) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - 1'b1;
`ifdef MULT_ITER_EN
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
`endif
      end
      if (w_finish) begin
        o_result <= w_res;
        o_flag_n <= w_res[N-1];
        o_flag_z <= w_z_en && (w_res == '0);
        o_flag_c <= w_c;
        o_flag_v <= w_v;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_flags.sv
// tb/tb_seq_alu_flags.sv - scoreboard testbench for seq_alu_flags (N=4)
// Driver pushes expected results; a negedge monitor pops and checks on every done.
module tb_seq_alu_flags;
  localparam int N = 4;
`ifdef MULT_ITER_EN
  localparam int MUL_LAT = N + 1;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam int DIV_LAT = N + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  typedef struct {
    logic [N-1:0] res;
    logic [3:0]   nzcv;
    int           t;
    int           lat;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_alu_flags #(.N(N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result),
    .o_flag_n (flag_n),
    .o_flag_z (flag_z),
    .o_flag_c (flag_c),
    .o_flag_v (flag_v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(e.nzcv));
        chk({e.name, "_latency"}, 32'(cyc - e.t), 32'(e.lat));
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 30);
    chk({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Called at a negedge; start is sampled on the following posedge (edge t = cyc+1).
  task automatic issue(input string name, input logic [3:0] o, input logic [N-1:0] va,
                       input logic [N-1:0] vb, input logic [N-1:0] er, input logic [3:0] nzcv,
                       input int lat, input bit glitch);
    exp_t e;
    op = o;
    a = va;
    b = vb;
    start = 1'b1;
    e.res = er;
    e.nzcv = nzcv;
    e.t = cyc + 1;
    e.lat = lat;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = ~va;
    b = ~vb;
    op = 4'd0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    if (glitch) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(name);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
    rst = 1'b0;

    //        name        op     a        b        result   NZCV
    issue("add_9_8",    4'd0, 4'd9,    4'd8,    4'd1,    4'b0011, 1, 0);
    issue("sub_3_5",    4'd1, 4'd3,    4'd5,    4'd14,   4'b1010, 1, 0);
    issue("div_13_3",   4'd3, 4'd13,   4'd3,    4'd4,    4'b0000, DIV_LAT, 1);
    issue("div_7_0",    4'd3, 4'd7,    4'd0,    4'd0,    4'b0001, 1, 0);
    issue("mod_13_3",   4'd4, 4'd13,   4'd3,    4'd1,    4'b0000, DIV_LAT, 0);
    issue("shl_b_1",    4'd8, 4'b1011, 4'd1,    4'b0110, 4'b0010, 1, 0);
    issue("shr_b_5",    4'd9, 4'b1011, 4'd5,    4'd0,    4'b0100, 1, 0);
    issue("mul_5_4",    4'd2, 4'd5,    4'd4,    4'd4,    4'b0010, MUL_LAT, 0);
    issue("div_0_5",    4'd3, 4'd0,    4'd5,    4'd0,    4'b0100, DIV_LAT, 0);
    issue("add_7_1",    4'd0, 4'd7,    4'd1,    4'd8,    4'b1001, 1, 0);
    issue("sub_5_5",    4'd1, 4'd5,    4'd5,    4'd0,    4'b0100, 1, 0);
    issue("illegal_12", 4'd12, 4'd0,   4'd0,    4'd0,    4'b0000, 1, 0);
    issue("xor",        4'd7, 4'b1010, 4'b0110, 4'b1100, 4'b1000, 1, 0);
    issue("shr_b_1",    4'd9, 4'b1011, 4'd1,    4'd5,    4'b0010, 1, 0);
    issue("shl_b_4",    4'd8, 4'b1011, 4'd4,    4'd0,    4'b0110, 1, 0);
    issue("mod_15_4",   4'd4, 4'd15,   4'd4,    4'd3,    4'b0000, DIV_LAT, 0);
    issue("and",        4'd5, 4'b1100, 4'b1010, 4'b1000, 4'b1000, 1, 0);
    issue("or_zero",    4'd6, 4'd0,    4'd0,    4'd0,    4'b0100, 1, 0);
    issue("mul_15_15",  4'd2, 4'd15,   4'd15,   4'd1,    4'b0010, MUL_LAT, 0);

    // Abort a divide with reset: no done may follow, outputs clear.
    op = 4'd3;
    a = 4'd13;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
    repeat (8) @(negedge clk);
    issue("add_after_abort", 4'd0, 4'd2, 4'd3, 4'd5, 4'b0000, 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
